vga_plot_arbiter: RTL and testbench

- Shares the single pixel-write port of the VGA adapter (160x120, 3-bit colour) between NUM_REQ drawing clients, e.g. gui key highlights, playback indicators and status bars.
- Each client requests a filled rectangle (origin, width, height, colour).
- The block grants requests round-robin and rasterises the granted rectangle, one pixel per clock.
- Sits between the drawing clients and vga_adapter's x/y/colour/plot inputs.

---
 rtl/vga_draw_pkg.sv | 25 ++
 rtl/vga_plot_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/vga_plot_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_draw_pkg.sv
// Shared constants and types for the VGA rectangle plotter: screen geometry,
// coordinate widths, the rasteriser state encoding and the rectangle record.
package vga_draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x0;
        logic [Y_W-1:0]      y0;
        logic [X_W-1:0]      w;
        logic [Y_W-1:0]      h;
        logic [COLOUR_W-1:0] colour;
    } rect_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Client request bus plus the vga_adapter pixel port of vga_plot_arbiter.
// master = drawing clients / adapter side, slave = the arbiter itself.
interface vga_plot_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    import vga_draw_pkg::*;

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*X_W-1:0]      req_x;
    logic [NUM_REQ*Y_W-1:0]      req_y;
    logic [NUM_REQ*X_W-1:0]      req_w;
    logic [NUM_REQ*Y_W-1:0]      req_h;
    logic [NUM_REQ*COLOUR_W-1:0] req_colour;
    logic [NUM_REQ-1:0]          ack;
    logic [NUM_REQ-1:0]          done;
    logic [X_W-1:0]              x;
    logic [Y_W-1:0]              y;
    logic [COLOUR_W-1:0]         colour;
    logic                        plot;
    logic                        busy;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  ack, done, x, y, colour, plot, busy
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output ack, done, x, y, colour, plot, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first set request found at
// ptr, ptr+1, ... modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Scan farthest-first so the candidate nearest the pointer is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter and filled-rectangle rasteriser driving vga_adapter, one pixel per clock.
// Optional: define VGA_PLOT_ARBITER_CLIP_EN to suppress plot for off-screen pixels.
module vga_plot_arbiter
    import vga_draw_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic               clock,
    input logic               reset,
    vga_plot_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    rect_t               rect_q, rect_d;
    rect_t               req_rect [NUM_REQ];
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [X_W-1:0]      cx_q, cx_d, x_q, x_d;
    logic [Y_W-1:0]      cy_q, cy_d, y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                last_x, last_y;
    logic                drawing;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_rect[i] = '{
            x0:     bus.req_x[i*X_W +: X_W],
            y0:     bus.req_y[i*Y_W +: Y_W],
            w:      bus.req_w[i*X_W +: X_W],
            h:      bus.req_h[i*Y_W +: Y_W],
            colour: bus.req_colour[i*COLOUR_W +: COLOUR_W]
        };
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (bus.req),
        .ptr   (ptr_q),
        .grant (pick_idx),
        .valid (pick_valid)
    );

`ifdef VGA_PLOT_ARBITER_CLIP_EN
    localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(SCREEN_H);

    // Visibility is judged on the untruncated sum, so a wrapped coordinate is never plotted.
    function automatic logic on_screen(input logic [X_W-1:0] ox, input logic [X_W-1:0] dx,
                                       input logic [Y_W-1:0] oy, input logic [Y_W-1:0] dy);
        logic [X_W:0] fx;
        logic [Y_W:0] fy;
        fx = {1'b0, ox} + {1'b0, dx};
        fy = {1'b0, oy} + {1'b0, dy};
        return (fx < X_LIMIT) && (fy < Y_LIMIT);
    endfunction
`endif

    assign last_x = (cx_q == rect_q.w - X_W'(1));
    assign last_y = (cy_q == rect_q.h - Y_W'(1));

    // cx/cy name the pixel that will be on the output pins in the next cycle.
    always_comb begin
        state_d  = state_q;
        rect_d   = rect_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        ack_d    = '0;
        done_d   = '0;
        drawing  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    rect_d          = req_rect[pick_idx];
                    gnt_d           = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    cx_d            = '0;
                    cy_d            = '0;
                    if (rect_d.w == '0 || rect_d.h == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAW;
                        drawing = 1'b1;
                    end
                end
            end

            DRAW: begin
                if (last_x && last_y) begin
                    state_d       = DONE;
                    done_d[gnt_q] = 1'b1;
                end else begin
                    drawing = 1'b1;
                    if (last_x) begin
                        cx_d = '0;
                        cy_d = cy_q + Y_W'(1);
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                end
            end

            DONE: begin
                // A zero-sized rectangle reaches DONE without its pulse; issue it here first.
                if (|done_q) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                end else begin
                    done_d[gnt_q] = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (drawing) begin
            x_d      = rect_d.x0 + cx_d;
            y_d      = rect_d.y0 + cy_d;
            colour_d = rect_d.colour;
`ifdef VGA_PLOT_ARBITER_CLIP_EN
            plot_d   = on_screen(rect_d.x0, cx_d, rect_d.y0, cy_d);
`else
            plot_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rect_q   <= '0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            done_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            rect_q   <= rect_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= (state_d != IDLE);
            ack_q    <= ack_d;
            done_q   <= done_d;
        end
    end

    assign bus.ack    = ack_q;
    assign bus.done   = done_q;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed cases then random rectangles, each checked
// cycle by cycle against a pixel-list model. Follows VGA_PLOT_ARBITER_CLIP_EN like the RTL.
module tb_vga_plot_arbiter;
    import vga_draw_pkg::*;

    localparam int N = 4;

    logic  clk;
    logic  rst_n;
    int    checks = 0;
    int    errors = 0;
    string step   = "init";
    int    ptr    = 0;
    int    cl_x [N];
    int    cl_y [N];
    int    cl_w [N];
    int    cl_h [N];
    int    cl_c [N];

    vga_plot_arbiter_if #(.NUM_REQ(N)) bus ();

    vga_plot_arbiter #(.NUM_REQ(N)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requesting client at p, p+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] mask, input int p);
        for (int i = 0; i < N; i++) begin
            if (mask[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    task automatic set_client(input int i, input int x, input int y, input int w,
                              input int h, input int c);
        cl_x[i] = x;
        cl_y[i] = y;
        cl_w[i] = w;
        cl_h[i] = h;
        cl_c[i] = c;
        bus.req_x[i*X_W +: X_W]                = X_W'(x);
        bus.req_y[i*Y_W +: Y_W]                = Y_W'(y);
        bus.req_w[i*X_W +: X_W]                = X_W'(w);
        bus.req_h[i*Y_W +: Y_W]                = Y_W'(h);
        bus.req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
        bus.req[i]                             = 1'b1;
    endtask

    // Called at a negedge with the DUT idle and client g about to be granted.
    task automatic expect_rect(input int g);
        int   x0, y0, w, h, c, n, d, p;
        logic vis;
        x0 = cl_x[g];
        y0 = cl_y[g];
        w  = cl_w[g];
        h  = cl_h[g];
        c  = cl_c[g];
        n  = w * h;
        d  = (n == 0) ? 2 : n + 1;
        for (int k = 1; k <= d + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("ack", bus.ack, (k == 1) ? (1 << g) : 0);
            check("done", bus.done, (k == d) ? (1 << g) : 0);
            check("busy", bus.busy, (k <= d) ? 1 : 0);
            p   = k - 1;
            vis = (k <= n);
`ifdef VGA_PLOT_ARBITER_CLIP_EN
            if (vis) vis = (x0 + p % w < SCREEN_W) && (y0 + p / w < SCREEN_H);
`endif
            check("plot", bus.plot, vis);
            if (vis) begin
                check("x", bus.x, (x0 + p % w) % (1 << X_W));
                check("y", bus.y, (y0 + p / w) % (1 << Y_W));
                check("colour", bus.colour, c);
            end
            if (k == 1) begin
                // Client lets go at ack and scribbles over its parameters.
                bus.req[g]                             = 1'b0;
                bus.req_x[g*X_W +: X_W]                = X_W'($urandom);
                bus.req_y[g*Y_W +: Y_W]                = Y_W'($urandom);
                bus.req_w[g*X_W +: X_W]                = X_W'($urandom);
                bus.req_h[g*Y_W +: Y_W]                = Y_W'($urandom);
                bus.req_colour[g*COLOUR_W +: COLOUR_W] = COLOUR_W'($urandom);
            end
        end
        ptr = (g + 1) % N;
    endtask

    task automatic serve_all(input logic [N-1:0] mask);
        int g;
        while (mask != '0) begin
            g       = pick(mask, ptr);
            expect_rect(g);
            mask[g] = 1'b0;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr   = 0;
    endtask

    initial begin
        logic [N-1:0] mask;
        clk            = 1'b0;
        rst_n          = 1'b1;
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_w      = '0;
        bus.req_h      = '0;
        bus.req_colour = '0;
        #2 rst_n = 1'b0;

        step = "reset";
        repeat (2) @(negedge clk);
        check("ack", bus.ack, 0);
        check("done", bus.done, 0);
        check("plot", bus.plot, 0);
        check("busy", bus.busy, 0);
        check("x", bus.x, 0);
        check("y", bus.y, 0);
        check("colour", bus.colour, 0);
        rst_n = 1'b1;

        step = "single";
        set_client(0, 10, 20, 3, 2, 3'b100);
        serve_all(4'b0001);

        step = "arb_round1";
        reset_dut();
        for (int i = 0; i < N; i++) set_client(i, 40 + i, 50 + i, 1, 1, i + 1);
        serve_all(4'b1111);

        step = "arb_round2";
        for (int i = 0; i < N; i++) set_client(i, 60 + 3 * i, 10 + i, 1, 1, 7 - i);
        serve_all(4'b1111);

        step = "ptr2";
        set_client(1, 5, 5, 2, 1, 6);
        serve_all(4'b0010);
        set_client(0, 1, 2, 1, 2, 1);
        set_client(2, 3, 4, 2, 1, 2);
        serve_all(4'b0101);

        step = "zero_size";
        set_client(1, 70, 30, 0, 5, 2);
        serve_all(4'b0010);

        step = "wrap";
        set_client(2, 158, 119, 4, 2, 5);
        serve_all(4'b0100);

        step = "mid_reset";
        reset_dut();
        set_client(0, 30, 40, 8, 8, 7);
        set_client(3, 90, 60, 2, 2, 3);
        @(posedge clk);
        @(negedge clk);
        check("ack", bus.ack, 1);
        bus.req[0] = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("plot10", bus.plot, 1);
        check("x10", bus.x, 31);
        check("y10", bus.y, 41);
        rst_n = 1'b0;
        #1;
        check("plot", bus.plot, 0);
        check("ack", bus.ack, 0);
        check("done", bus.done, 0);
        check("busy", bus.busy, 0);
        check("x", bus.x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr   = 0;
        serve_all(4'b1000);

        step = "random";
        for (int r = 0; r < 12; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    set_client(i, $urandom_range(0, 255), $urandom_range(0, 127),
                               $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 7));
                end
            end
            serve_all(mask);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
